// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl -- four-digit multiplexed seven-segment scan controller.
//
// Purpose:
//   Scans a four-digit hex display. Each digit is held for PRESCALE clocks,
//   then the scan moves to the next digit. A newly loaded value is parked in
//   a pending register and copied to the display register only at a frame
//   boundary, so a frame never shows a mix of old and new digits.
//
// Ports:
//   Clk        system clock; all state updates on its rising edge
//   ResetL     asynchronous active-low reset
//   Load       one-cycle strobe that captures Value
//   Value[15:0]  four hex digits; digit n = Value[4n+3:4n]
//   DigitSel[1:0]  index of the digit currently driven (to the anode decoder)
//   Nibble[3:0]    hex digit currently selected
//   Seg[6:0]       active-low segments {g,f,e,d,c,b,a}
//   Blank          high when the current digit is blanked
//   Pending        high while a loaded value waits for the frame boundary
//   FrameDone      one-cycle pulse in the cycle after each frame boundary
//
// Parameter:
//   PRESCALE   clocks each digit is held, 1..65535 (default 4)
//
// Build option:
//   SEG_SCAN_LZB_EN  when defined, digits above digit 0 whose value and all
//                    more significant digits are zero are blanked
//                    (leading-zero blanking). Undefined: Blank is tied low.

module seg_scan_ctrl #(
  parameter int PRESCALE = 4
) (
  input  logic        Clk,
  input  logic        ResetL,
  input  logic        Load,
  input  logic [15:0] Value,
  output logic [1:0]  DigitSel,
  output logic [3:0]  Nibble,
  output logic [6:0]  Seg,
  output logic        Blank,
  output logic        Pending,
  output logic        FrameDone
);

  localparam logic [15:0] LAST = 16'(PRESCALE - 1);

  logic [15:0] cnt;
  logic [1:0]  digit_q;
  logic [15:0] disp;
  logic [15:0] pend;
  logic        pend_vld;
  logic        frame_q;
  logic        tick;
  logic        boundary;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  assign tick     = (cnt == LAST);
  assign boundary = tick && (digit_q == 2'd3);

  // Scan timing and display/pending registers
  always_ff @(posedge Clk or negedge ResetL) begin
    if (!ResetL) begin
      cnt      <= '0;
      digit_q  <= '0;
      disp     <= '0;
      pend     <= '0;
      pend_vld <= 1'b0;
      frame_q  <= 1'b0;
    end else begin
      cnt     <= tick ? '0 : cnt + 16'd1;
      frame_q <= boundary;
      if (tick) begin
        digit_q <= digit_q + 2'd1;
      end
      if (boundary) begin
        // A load landing on the boundary bypasses the pending register and
        // takes priority over any older pending value.
        if (Load) begin
          disp <= Value;
        end else if (pend_vld) begin
          disp <= pend;
        end
        pend_vld <= 1'b0;
      end else if (Load) begin
        pend     <= Value;
        pend_vld <= 1'b1;
      end
    end
  end

  // Digit select and decode (combinational from the scan index)
  always_comb begin
    Nibble = 4'h0;
    case (digit_q)
      2'd0: Nibble = disp[3:0];
      2'd1: Nibble = disp[7:4];
      2'd2: Nibble = disp[11:8];
      default: Nibble = disp[15:12];
    endcase
  end

`ifdef SEG_SCAN_LZB_EN
  always_comb begin
    Blank = 1'b0;
    case (digit_q)
      2'd1: Blank = (disp[15:4] == 12'h000);
      2'd2: Blank = (disp[15:8] == 8'h00);
      2'd3: Blank = (disp[15:12] == 4'h0);
      default: Blank = 1'b0;
    endcase
  end
`else
  assign Blank = 1'b0;
`endif

  assign Seg       = Blank ? 7'b1111111 : hex_to_seg(Nibble);
  assign DigitSel  = digit_q;
  assign Pending   = pend_vld;
  assign FrameDone = frame_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
module tb_seg_scan_ctrl;

  logic        Clk = 1'b0;
  logic        ResetL;
  logic        Load;
  logic [15:0] Value;
  logic [1:0]  DigitSel;
  logic [3:0]  Nibble;
  logic [6:0]  Seg;
  logic        Blank;
  logic        Pending;
  logic        FrameDone;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  seg_scan_ctrl #(.PRESCALE(4)) dut (
    .Clk(Clk), .ResetL(ResetL), .Load(Load), .Value(Value),
    .DigitSel(DigitSel), .Nibble(Nibble), .Seg(Seg), .Blank(Blank),
    .Pending(Pending), .FrameDone(FrameDone)
  );

  always #5 Clk = ~Clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] seg_ref(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  function automatic logic blank_ref(input logic [15:0] v, input int d);
`ifdef SEG_SCAN_LZB_EN
    return (d != 0) && ((v >> (4 * d)) == 16'h0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) step();
  endtask

  task automatic load_val(input logic [15:0] v);
    Load = 1'b1;
    Value = v;
    step();
    Load = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_dsel"},  16'(DigitSel),  16'd0);
    chk({tag, "_nib"},   16'(Nibble),    16'd0);
    chk({tag, "_seg"},   16'(Seg),       16'b1000000);
    chk({tag, "_blank"}, 16'(Blank),     16'd0);
    chk({tag, "_pend"},  16'(Pending),   16'd0);
    chk({tag, "_fdone"}, 16'(FrameDone), 16'd0);
  endtask

  // Called right after a boundary edge; checks the whole frame and returns
  // right after the next boundary edge.
  task automatic check_frame(input string tag, input logic [15:0] v);
    logic [3:0] n;
    logic       b;
    chk({tag, "_fdone"}, 16'(FrameDone), 16'd1);
    for (int d = 0; d < 4; d++) begin
      n = 4'((v >> (4 * d)) & 16'hF);
      b = blank_ref(v, d);
      chk({tag, "_dsel"},  16'(DigitSel), 16'(d));
      chk({tag, "_nib"},   16'(Nibble),   16'(n));
      chk({tag, "_blank"}, 16'(Blank),    16'(b));
      chk({tag, "_seg"},   16'(Seg),      b ? 16'h7F : 16'(seg_ref(n)));
      chk({tag, "_pend"},  16'(Pending),  16'd0);
      repeat (4) step();
    end
  endtask

  initial begin
    ResetL = 1'b0;
    Load = 1'b0;
    Value = 16'h0;
    #12;
    chk_reset_outputs("por");
    @(posedge Clk); #1;
    ResetL = 1'b1;
    cyc = 0;

    // Free-running scan with no load
    for (int k = 1; k <= 16; k++) begin
      step();
      chk("scan_dsel",  16'(DigitSel),  16'((k / 4) % 4));
      chk("scan_fdone", 16'(FrameDone), (k % 16 == 0) ? 16'd1 : 16'd0);
      chk("scan_seg",   16'(Seg),       16'b1000000);
      chk("scan_pend",  16'(Pending),   16'd0);
    end
    step();
    chk("fdone_one_cycle", 16'(FrameDone), 16'd0);

    // Mid-frame load waits for the boundary
    run_to(20);
    load_val(16'h12AF);
    chk("mid_pend",      16'(Pending), 16'd1);
    chk("mid_nib_old",   16'(Nibble),  16'd0);
    run_to(31);
    chk("mid_pend_hold", 16'(Pending), 16'd1);
    chk("mid_dsel3",     16'(DigitSel), 16'd3);
    chk("mid_nib_hold",  16'(Nibble),  16'd0);
    run_to(32);
    check_frame("f12af", 16'h12AF);

    // Two loads in one frame: only the last applies
    run_to(50);
    load_val(16'h1111);
    load_val(16'h2222);
    chk("dbl_pend",     16'(Pending), 16'd1);
    chk("dbl_nib_old",  16'(Nibble),  16'hA);
    run_to(64);
    check_frame("f2222", 16'h2222);

    // Load exactly on the boundary cycle bypasses pending
    run_to(95);
    chk("bnd_pre_pend", 16'(Pending), 16'd0);
    load_val(16'h0BEE);
    check_frame("f0bee", 16'h0BEE);

    // Reset during digit 2 with a value pending
    run_to(113);
    load_val(16'h5555);
    run_to(120);
    chk("rst_pre_pend", 16'(Pending),  16'd1);
    chk("rst_pre_dsel", 16'(DigitSel), 16'd2);
    ResetL = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    @(posedge Clk); #1;
    chk_reset_outputs("held_rst");
    ResetL = 1'b1;
    cyc = 0;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("dwell_dsel", 16'(DigitSel), (k == 4) ? 16'd1 : 16'd0);
    end
    run_to(16);
    check_frame("discard", 16'h0000);

    // Load on the first edge after reset release is honoured
    ResetL = 1'b0;
    @(posedge Clk); #1;
    Load = 1'b1;
    Value = 16'h3C45;
    ResetL = 1'b1;
    cyc = 0;
    step();
    Load = 1'b0;
    chk("first_edge_pend", 16'(Pending), 16'd1);
    run_to(16);
    check_frame("f3c45", 16'h3C45);

    run_to(40);
    load_val(16'h6789);
    run_to(48);
    check_frame("f6789", 16'h6789);

    run_to(70);
    load_val(16'hD0D0);
    run_to(80);
    check_frame("fd0d0", 16'hD0D0);

    // Leading-zero patterns (blanked only in the LZB build)
    run_to(100);
    load_val(16'h0070);
    run_to(112);
    check_frame("f0070", 16'h0070);

    run_to(130);
    load_val(16'h0000);
    run_to(144);
    check_frame("f0000", 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter PRESCALE, default 4, clock cycles each digit is held; legal range 1..65535.
REQ-002 Clk  input  1  single system clock; all state updates on rising edge.
REQ-003 ResetL  input  1  asynchronous, active-low reset.
REQ-004 Load  input  1  one-cycle strobe; captures Value into the pending register.
REQ-005 Value  input  16  four hex digits; digit n = Value[4n+3:4n].
REQ-006 DigitSel  output  2  index of the digit currently driven; feeds the 2-to-4 anode decoder.
REQ-007 Nibble  output  4  hex digit currently selected.
REQ-008 Seg  output  7  active-low segments {g,f,e,d,c,b,a} for Nibble.
REQ-009 Blank  output  1  high when the current digit is blanked.
REQ-010 Pending  output  1  high while a loaded value waits for the frame boundary.
REQ-011 FrameDone  output  1  one-cycle pulse at each frame boundary.

Function
REQ-012 Prescale counter SHALL count 0..PRESCALE-1 and wrap to 0; "tick" SHALL be asserted in the cycle where the counter equals PRESCALE-1.
REQ-013 On tick, DigitSel SHALL increment by 1 modulo 4 (3 wraps to 0); otherwise it SHALL hold.
REQ-014 PRESCALE=1 SHALL tick every cycle (DigitSel advances each cycle).
REQ-015 Frame boundary SHALL be tick while DigitSel==3; FrameDone SHALL be registered high for exactly the cycle after the boundary edge.
REQ-016 Load=1 SHALL write Value into the pending register and set Pending on the next edge.
REQ-017 At the boundary edge with Pending=1 and Load=0, the display register SHALL take the pending register and Pending SHALL clear.
REQ-018 Load=1 coincident with the boundary SHALL write Value directly into the display register; Pending SHALL be 0 afterwards.
REQ-019 Load while Pending=1 (not at boundary) SHALL overwrite the pending register; only the last value is applied.
REQ-020 Display register SHALL change only at frame boundaries; no partially updated frame is ever shown.
REQ-021 Nibble SHALL be combinational: display[4*DigitSel+3:4*DigitSel], zero latency from DigitSel.
REQ-022 Seg SHALL be combinational hex decode of Nibble (active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-023 When Blank=1, Seg SHALL be 1111111 regardless of Nibble.

Reset
REQ-024 ResetL low SHALL immediately force: prescale counter 0, DigitSel 0, display and pending registers 0, Pending 0, FrameDone 0; thus Nibble 0, Seg 1000000, Blank 0.
REQ-025 Reset asserted mid-frame or with Pending=1 SHALL discard the pending value; scanning restarts at digit 0 with a full PRESCALE dwell after ResetL rises.
REQ-026 Load sampled high in the first edge after ResetL rises SHALL be honoured.

Configuration
REQ-027 Macro SEG_SCAN_LZB_EN: when defined, digits n>0 with display[15:4n] all zero SHALL set Blank=1 (leading-zero blanking); digit 0 is never blanked.
REQ-028 Without SEG_SCAN_LZB_EN, Blank SHALL be constant 0 and no blanking logic is generated; all other behaviour is identical.

Verification (PRESCALE=4)
REQ-029 Reset release, no Load -> DigitSel sequence 0,0,0,0,1,1,1,1,2..3 then 0; FrameDone pulses every 16 cycles; Seg=1000000 throughout.
REQ-030 Load Value=0x12AF mid-frame -> Pending=1 until boundary; next frame: digit0 Seg=0001110, digit1 0001000, digit2 0100100, digit3 1111001; Pending=0.
REQ-031 Load 0x1111 then 0x2222 in the same frame -> next frame shows only 0x2222 on all digits.
REQ-032 Load 0x0BEE exactly on boundary cycle -> shown in the immediately following frame, Pending never asserted.
REQ-033 ResetL pulsed low during digit 2 with Pending=1 -> outputs at reset values immediately; pending value never displayed.
REQ-034 With SEG_SCAN_LZB_EN, display 0x0070 -> digits 3,2 Blank=1, Seg=1111111; digit1 Seg=1111000; digit0 Seg=1000000; display 0x0000 -> only digit 0 unblanked.
